wb_stage: RTL and testbench

//  Writeback stage of the 24-bit pipeline. Sole driver of the register file write port.

---
 rtl/wb_pkg.sv | 9 +
 rtl/wb_stage.sv | 97 +++++++++
 tb/tb_wb_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback stage of the 24-bit pipeline.
package wb_pkg;
    localparam int DATA_W = 24;
    localparam int REG_AW = 4;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK, WB_RSVD} wb_sel_e;
    typedef enum logic [1:0] {EMPTY, WAIT_MEM, COMMIT} wb_state_e;
endpackage

// File: rtl/wb_stage.sv
// Writeback stage: selects ALU/load/link result, sole register file writer, forwards each write.
// Latency: commit 1 cycle after capture (non-load) or 1 cycle after mem_rvalid (load).
// Backpressure: wb_busy high while a load is outstanding; upstream must hold its bundle.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int REG_AW = wb_pkg::REG_AW,
    parameter int CNT_W  = wb_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        in_wb_sel,
    input  logic              in_wr_en,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_link_addr,
    input  logic              flush,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_busy,
    output logic              reg_write_en,
    output logic [REG_AW-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired_count
);

    wb_state_e         state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              capture;
    logic              in_commit;

    assign wb_busy   = (state_q == WAIT_MEM);
    assign capture   = in_valid & ~wb_busy & ~flush;
    assign in_commit = (state_q == COMMIT);

    always_comb begin
        state_d = state_q;
        wr_en_d = wr_en_q;
        dest_d  = dest_q;
        data_d  = data_q;
        case (state_q)
            WAIT_MEM: begin
                // flush has priority over a returning load
                if (flush) begin
                    state_d = EMPTY;
                end else if (mem_rvalid) begin
                    state_d = COMMIT;
                    data_d  = mem_rdata;
                end
            end
            default: begin
                state_d = EMPTY;
                if (capture) begin
                    wr_en_d = in_wr_en;
                    dest_d  = in_dest;
                    data_d  = (in_wb_sel == WB_LINK) ? in_link_addr : in_alu_result;
                    state_d = (in_wb_sel == WB_MEM) ? WAIT_MEM : COMMIT;
                end
            end
        endcase
        // Count on entry so the value seen during COMMIT already includes it.
        cnt_d = (state_d == COMMIT) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            wr_en_q <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign reg_write_en   = in_commit & wr_en_q & (dest_q != '0);
    assign reg_write_dest = in_commit ? dest_q : '0;
    assign reg_write_data = in_commit ? data_q : '0;
    assign fwd_valid      = reg_write_en;
    assign fwd_dest       = reg_write_dest;
    assign fwd_data       = reg_write_data;
    assign retired_count  = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: hand-computed vectors per feature, inline comparisons.
module tb_wb_stage;
    logic        clk, rst;
    logic        in_valid, in_wr_en, flush, mem_rvalid;
    logic [1:0]  in_wb_sel;
    logic [3:0]  in_dest;
    logic [23:0] in_alu_result, in_link_addr, mem_rdata;
    logic        wb_busy, reg_write_en, fwd_valid;
    logic [3:0]  reg_write_dest, fwd_dest;
    logic [23:0] reg_write_data, fwd_data;
    logic [15:0] retired_count;

    int vectors = 0;
    int miscompares = 0;

    wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_wb_sel(in_wb_sel),
        .in_wr_en(in_wr_en), .in_dest(in_dest), .in_alu_result(in_alu_result),
        .in_link_addr(in_link_addr), .flush(flush), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_busy(wb_busy), .reg_write_en(reg_write_en),
        .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .retired_count(retired_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(in_valid && wb_busy)) else $error("protocol: in_valid while wb_busy");
            assert (!(mem_rvalid && !wb_busy)) else $error("protocol: mem_rvalid outside WAIT_MEM");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic we,
                         input logic [3:0] d, input logic [23:0] alu, input logic [23:0] link);
        in_valid = v; in_wb_sel = sel; in_wr_en = we; in_dest = d;
        in_alu_result = alu; in_link_addr = link;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({wb_busy, reg_write_en, reg_write_dest, reg_write_data, retired_count} !== 46'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%0b en=%0b dest=%0h data=%0h cnt=%0h want all 0",
                     wb_busy, reg_write_en, reg_write_dest, reg_write_data, retired_count);
        end
        vectors++;
        if ({fwd_valid, fwd_dest, fwd_data} !== 29'd0) begin
            miscompares++;
            $display("FAIL reset_fwd: got %0b/%0h/%0h want 0", fwd_valid, fwd_dest, fwd_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu();
        drive(1'b1, 2'd0, 1'b1, 4'd3, 24'h040000, 24'h000123);
        tick();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 24'h0, 24'h0);
        vectors++;
        if ({reg_write_en, reg_write_dest, reg_write_data, retired_count} !== {1'b1, 4'd3, 24'h040000, 16'd1}) begin
            miscompares++;
            $display("FAIL alu_commit: got en=%0b dest=%0h data=%0h cnt=%0h want 1/3/40000/1",
                     reg_write_en, reg_write_dest, reg_write_data, retired_count);
        end
        vectors++;
        if ({fwd_valid, fwd_dest, fwd_data} !== {1'b1, 4'd3, 24'h040000}) begin
            miscompares++;
            $display("FAIL alu_fwd: got %0b/%0h/%0h want 1/3/40000", fwd_valid, fwd_dest, fwd_data);
        end
        tick();
        vectors++;
        if ({reg_write_en, reg_write_dest, reg_write_data} !== 29'd0) begin
            miscompares++;
            $display("FAIL alu_idle: got en=%0b dest=%0h data=%0h want 0", reg_write_en, reg_write_dest, reg_write_data);
        end
    endtask

    task automatic test_load();
        drive(1'b1, 2'd1, 1'b1, 4'd5, 24'h000777, 24'h0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 24'h0, 24'h0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({wb_busy, reg_write_en} !== 2'b10) begin
                miscompares++;
                $display("FAIL load_busy[%0d]: got busy=%0b en=%0b want 1/0", i, wb_busy, reg_write_en);
            end
            if (i == 2) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 24'h03EFFF;
            end
            tick();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 24'h0;
        vectors++;
        if ({wb_busy, reg_write_en, reg_write_dest, reg_write_data, retired_count} !== {1'b0, 1'b1, 4'd5, 24'h03EFFF, 16'd2}) begin
            miscompares++;
            $display("FAIL load_commit: got busy=%0b en=%0b dest=%0h data=%0h cnt=%0h want 0/1/5/3efff/2",
                     wb_busy, reg_write_en, reg_write_dest, reg_write_data, retired_count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'd0, 1'b1, 4'd1, 24'h001000, 24'h0);
        tick();
        vectors++;
        if ({reg_write_en, reg_write_dest, reg_write_data, retired_count} !== {1'b1, 4'd1, 24'h001000, 16'd3}) begin
            miscompares++;
            $display("FAIL b2b_alu: got en=%0b dest=%0h data=%0h cnt=%0h want 1/1/1000/3",
                     reg_write_en, reg_write_dest, reg_write_data, retired_count);
        end
        drive(1'b1, 2'd2, 1'b1, 4'd2, 24'h000BAD, 24'h01CAC5);
        tick();
        vectors++;
        if ({reg_write_en, reg_write_dest, reg_write_data, retired_count} !== {1'b1, 4'd2, 24'h01CAC5, 16'd4}) begin
            miscompares++;
            $display("FAIL b2b_link: got en=%0b dest=%0h data=%0h cnt=%0h want 1/2/1cac5/4",
                     reg_write_en, reg_write_dest, reg_write_data, retired_count);
        end
        drive(1'b1, 2'd0, 1'b1, 4'd0, 24'h000055, 24'h0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 24'h0, 24'h0);
        vectors++;
        if ({reg_write_en, fwd_valid, retired_count} !== {1'b0, 1'b0, 16'd5}) begin
            miscompares++;
            $display("FAIL b2b_r0: got en=%0b fwd=%0b cnt=%0h want 0/0/5", reg_write_en, fwd_valid, retired_count);
        end
        tick();
    endtask

    task automatic test_rsvd_and_nowrite();
        drive(1'b1, 2'd3, 1'b1, 4'd4, 24'h00ABCD, 24'h001111);
        tick();
        vectors++;
        if ({reg_write_en, reg_write_dest, reg_write_data, retired_count} !== {1'b1, 4'd4, 24'h00ABCD, 16'd6}) begin
            miscompares++;
            $display("FAIL rsvd_sel: got en=%0b dest=%0h data=%0h cnt=%0h want 1/4/abcd/6",
                     reg_write_en, reg_write_dest, reg_write_data, retired_count);
        end
        drive(1'b1, 2'd0, 1'b0, 4'd7, 24'h000042, 24'h0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 24'h0, 24'h0);
        vectors++;
        if ({reg_write_en, retired_count} !== {1'b0, 16'd7}) begin
            miscompares++;
            $display("FAIL nowrite: got en=%0b cnt=%0h want 0/7", reg_write_en, retired_count);
        end
        tick();
    endtask

    task automatic test_flush();
        // flush during COMMIT must not cancel the write
        drive(1'b1, 2'd0, 1'b1, 4'd8, 24'h000008, 24'h0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 24'h0, 24'h0);
        flush = 1'b1;
        #1;
        vectors++;
        if ({reg_write_en, reg_write_dest, reg_write_data, retired_count} !== {1'b1, 4'd8, 24'h000008, 16'd8}) begin
            miscompares++;
            $display("FAIL flush_commit: got en=%0b dest=%0h data=%0h cnt=%0h want 1/8/8/8",
                     reg_write_en, reg_write_dest, reg_write_data, retired_count);
        end
        tick();
        flush = 1'b0;
        drive(1'b1, 2'd1, 1'b1, 4'd6, 24'h0, 24'h0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 24'h0, 24'h0);
        tick();
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 24'h001234;
        tick();
        flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = 24'h0;
        vectors++;
        if ({wb_busy, reg_write_en, retired_count} !== {1'b0, 1'b0, 16'd8}) begin
            miscompares++;
            $display("FAIL flush_load: got busy=%0b en=%0b cnt=%0h want 0/0/8", wb_busy, reg_write_en, retired_count);
        end
        tick();
        vectors++;
        if ({reg_write_en, retired_count} !== {1'b0, 16'd8}) begin
            miscompares++;
            $display("FAIL flush_after: got en=%0b cnt=%0h want 0/8", reg_write_en, retired_count);
        end
        drive(1'b1, 2'd0, 1'b1, 4'd9, 24'h000099, 24'h0);
        flush = 1'b1;
        tick();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 24'h0, 24'h0);
        flush = 1'b0;
        vectors++;
        if ({reg_write_en, retired_count} !== {1'b0, 16'd8}) begin
            miscompares++;
            $display("FAIL flush_blocks_capture: got en=%0b cnt=%0h want 0/8", reg_write_en, retired_count);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 2'd1, 1'b1, 4'd7, 24'h0, 24'h0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 24'h0, 24'h0);
        vectors++;
        if (wb_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre_busy: got %0b want 1", wb_busy);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({wb_busy, reg_write_en, reg_write_dest, reg_write_data, fwd_valid, retired_count} !== 47'd0) begin
            miscompares++;
            $display("FAIL midrst_async: got busy=%0b en=%0b dest=%0h data=%0h fwd=%0b cnt=%0h want all 0",
                     wb_busy, reg_write_en, reg_write_dest, reg_write_data, fwd_valid, retired_count);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++;
        if ({wb_busy, reg_write_en, retired_count} !== 18'd0) begin
            miscompares++;
            $display("FAIL midrst_empty: got busy=%0b en=%0b cnt=%0h want 0/0/0", wb_busy, reg_write_en, retired_count);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 2'd0, 1'b1, 4'd9, 24'h000001, 24'h0);
        repeat (65535) tick();
        vectors++;
        if (retired_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_preload: got cnt=%0h want ffff", retired_count);
        end
        drive(1'b1, 2'd0, 1'b1, 4'd10, 24'h00FACE, 24'h0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 24'h0, 24'h0);
        vectors++;
        if ({reg_write_en, reg_write_dest, reg_write_data, retired_count} !== {1'b1, 4'd10, 24'h00FACE, 16'd0}) begin
            miscompares++;
            $display("FAIL wrap_commit: got en=%0b dest=%0h data=%0h cnt=%0h want 1/a/face/0",
                     reg_write_en, reg_write_dest, reg_write_data, retired_count);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = 24'h0;
        drive(1'b0, 2'd0, 1'b0, 4'd0, 24'h0, 24'h0);
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_rsvd_and_nowrite();
        test_flush();
        test_mid_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
